// File: rtl/soc_io_interconnect.sv
// Page decoder, strobe generator and read mux between the FemtoRV32 memory port and
// RAM plus N_IO peripheral slots, with busy handshake, timeout and error reporting.
module soc_io_interconnect #(
  parameter int unsigned N_IO      = 5,
  parameter logic [15:0] IO_PAGE   = 16'h0040,
  parameter int unsigned RSV_PAGES = 16,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_VALUE = 32'h66666666,
  localparam int unsigned NS = N_IO + 1,
  localparam int unsigned SW = $clog2(NS),
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      mem_addr,
  input  logic             mem_rstrb,
  input  logic [3:0]       mem_wmask,
  output logic [31:0]      mem_rdata,
  output logic             mem_rbusy,
  output logic             mem_wbusy,
  output logic [NS-1:0]    s_cs,
  output logic [NS-1:0]    s_rd,
  output logic [NS-1:0]    s_wr,
  input  logic [32*NS-1:0] s_rdata,
  input  logic [NS-1:0]    s_busy,
  input  logic             err_clr,
  output logic             err_irq,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {IDLE, RWAIT, WWAIT, ERR} state_t;

  state_t        state;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] slot_c;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic [31:0]   sel_rdata;
  logic [16:0]   page_c;
  logic          io_hit;
  logic          rsv_hit;
  logic          rd_req;
  logic          wr_req;
  logic          any_req;
  logic          idle;
  logic          waiting;
  logic          busy_sel;
  logic          timeout_hit;
  logic          err_event;
  logic          unused_addr;

  assign unused_addr = ^mem_addr[15:0];

  // Page decode; one extra bit keeps the upper-bound compares from wrapping.
  always_comb begin
    page_c  = {1'b0, mem_addr[31:16]};
    io_hit  = (page_c >= 17'(IO_PAGE)) && (page_c < 17'(IO_PAGE) + 17'(N_IO));
    rsv_hit = (page_c >= 17'(IO_PAGE) + 17'(N_IO)) &&
              (page_c < 17'(IO_PAGE) + 17'(RSV_PAGES));
    slot_c  = io_hit ? SW'(page_c - 17'(IO_PAGE) + 17'd1) : '0;
    s_cs    = rsv_hit ? '0 : (NS'(1) << slot_c);
  end

  // A simultaneous read and write issues only the write.
  assign wr_req  = |mem_wmask;
  assign rd_req  = mem_rstrb & ~wr_req;
  assign any_req = mem_rstrb | wr_req;
  assign idle    = (state == IDLE);
  assign waiting = (state == RWAIT) || (state == WWAIT);

  assign s_wr = (resetn && idle && wr_req) ? s_cs : '0;
  assign s_rd = (resetn && idle && rd_req) ? s_cs : '0;

  assign busy_sel    = s_busy[sel_q];
  assign sel_rdata   = s_rdata[{sel_q, 5'd0} +: 32];
  assign timeout_hit = (TIMEOUT != 0) && waiting && busy_sel && (cnt == CW'(TIMEOUT));
  assign err_event   = (idle && any_req && rsv_hit) || timeout_hit;

  assign mem_rbusy = (state == RWAIT) && busy_sel && !timeout_hit;
  assign mem_wbusy = (state == WWAIT) && busy_sel && !timeout_hit;

  always_comb begin
    mem_rdata = rdata_q;
    if ((state == ERR) || timeout_hit) mem_rdata = ERR_VALUE;
    else if (state == RWAIT)           mem_rdata = sel_rdata;
  end

  // Transaction FSM with slot latch, busy-cycle counter and read-data hold register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      sel_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (any_req) begin
            if (rsv_hit) begin
              state <= ERR;
            end else begin
              sel_q <= slot_c;
              state <= wr_req ? WWAIT : RWAIT;
            end
          end
        end
        RWAIT, WWAIT: begin
          if (!busy_sel || timeout_hit) begin
            state <= IDLE;
            if (state == RWAIT) rdata_q <= timeout_hit ? ERR_VALUE : sel_rdata;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flag and saturating error counter; a new error beats err_clr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_irq   <= 1'b0;
      err_count <= '0;
    end else if (err_event) begin
      err_irq <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end else if (err_clr) begin
      err_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_soc_io_interconnect.sv
// Randomized self-checking bench for soc_io_interconnect against a transaction-level
// model of decode, slave latency, timeout and error bookkeeping.
module tb_soc_io_interconnect;

  localparam int unsigned NIO  = 5;
  localparam int unsigned NS   = NIO + 1;
  localparam int unsigned TO   = 8;
  localparam int unsigned IOP  = 'h40;
  localparam int unsigned RSV  = 16;
  localparam logic [31:0] ERRV = 32'h66666666;

  logic             clk = 1'b0;
  logic             resetn;
  logic [31:0]      mem_addr;
  logic             mem_rstrb;
  logic [3:0]       mem_wmask;
  logic [31:0]      mem_rdata;
  logic             mem_rbusy;
  logic             mem_wbusy;
  logic [NS-1:0]    s_cs;
  logic [NS-1:0]    s_rd;
  logic [NS-1:0]    s_wr;
  logic [32*NS-1:0] s_rdata;
  logic [NS-1:0]    s_busy;
  logic             err_clr;
  logic             err_irq;
  logic [15:0]      err_count;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_last_rd = '0;
  int          m_err_cnt = 0;
  bit          m_irq = 1'b0;

  soc_io_interconnect #(.N_IO(NIO), .IO_PAGE(16'h0040), .RSV_PAGES(RSV),
                        .TIMEOUT(TO), .ERR_VALUE(ERRV)) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
    .mem_wbusy(mem_wbusy), .s_cs(s_cs), .s_rd(s_rd), .s_wr(s_wr),
    .s_rdata(s_rdata), .s_busy(s_busy), .err_clr(err_clr), .err_irq(err_irq),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec-level decode: slot number, or reserved page.
  function automatic void decode(input logic [31:0] a, output int slot, output bit rsv);
    int p;
    p = int'(a[31:16]);
    rsv = 1'b0;
    slot = 0;
    if (p >= IOP && p < IOP + NIO) slot = p - IOP + 1;
    else if (p >= IOP + NIO && p < IOP + RSV) begin rsv = 1'b1; slot = -1; end
  endfunction

  // Random data/busy on every slot; the addressed slot returns its programmed word.
  task automatic noise(input int slot, input logic [31:0] data);
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = $urandom;
    if (slot >= 0) s_rdata[32*slot +: 32] = data;
    s_busy = NS'($urandom);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rdata"}, mem_rdata, 32'h0);
    check({tag, "_rbusy"}, 32'(mem_rbusy), 32'h0);
    check({tag, "_wbusy"}, 32'(mem_wbusy), 32'h0);
    check({tag, "_irq"}, 32'(err_irq), 32'h0);
    check({tag, "_cnt"}, 32'(err_count), 32'h0);
    check({tag, "_s_rd"}, 32'(s_rd), 32'h0);
    check({tag, "_s_wr"}, 32'(s_wr), 32'h0);
  endtask

  // One CPU access; slave holds busy for lat cycles after the strobe.
  task automatic access(input logic [31:0] addr, input bit rd, input logic [3:0] wm,
                        input int lat, input logic [31:0] data, input bit clr);
    int slot, stall;
    bit rsv, is_wr, timed_out;
    logic [NS-1:0] exp_cs;
    decode(addr, slot, rsv);
    is_wr = (wm != 4'd0);
    exp_cs = rsv ? '0 : (NS'(1) << slot);
    stall = (lat < int'(TO)) ? lat : int'(TO);
    timed_out = (lat > int'(TO));

    @(negedge clk);
    mem_addr = addr; mem_rstrb = rd; mem_wmask = wm; err_clr = 1'b0;
    noise(slot, data);
    #1;
    check("cs", 32'(s_cs), 32'(exp_cs));
    check("s_rd", 32'(s_rd), (rd && !is_wr) ? 32'(exp_cs) : 32'h0);
    check("s_wr", 32'(s_wr), is_wr ? 32'(exp_cs) : 32'h0);
    check("idle_rbusy", 32'(mem_rbusy), 32'h0);

    if (rsv) begin
      @(negedge clk);
      mem_addr = $urandom; mem_rstrb = 1'($urandom); mem_wmask = 4'($urandom);
      err_clr = clr;
      noise(-1, 32'h0);
      #1;
      check("err_rdata", mem_rdata, ERRV);
      check("err_s_rd", 32'(s_rd), 32'h0);
      check("err_s_wr", 32'(s_wr), 32'h0);
      check("err_rbusy", 32'(mem_rbusy | mem_wbusy), 32'h0);
      if (m_err_cnt < 16'hFFFF) m_err_cnt++;
      m_irq = !clr;
    end else begin
      for (int c = 1; c <= stall + 1; c++) begin
        @(negedge clk);
        mem_addr = $urandom; mem_rstrb = 1'($urandom); mem_wmask = 4'($urandom);
        err_clr = (c == stall + 1) ? clr : 1'b0;
        noise(slot, data);
        s_busy[slot] = (c <= lat);
        #1;
        check("wait_s_rd", 32'(s_rd), 32'h0);
        check("wait_s_wr", 32'(s_wr), 32'h0);
        check("rbusy", 32'(mem_rbusy), 32'(!is_wr && c <= stall));
        check("wbusy", 32'(mem_wbusy), 32'(is_wr && c <= stall));
        if (c == stall + 1 && (!is_wr || timed_out))
          check("done_rdata", mem_rdata, timed_out ? ERRV : data);
      end
      if (timed_out) begin
        if (m_err_cnt < 16'hFFFF) m_err_cnt++;
        m_irq = 1'b1;
      end else if (clr) m_irq = 1'b0;
      if (!is_wr) m_last_rd = timed_out ? ERRV : data;
    end

    @(negedge clk);
    mem_rstrb = 1'b0; mem_wmask = 4'd0; err_clr = 1'b0;
    noise(-1, 32'h0);
    #1;
    check("post_cnt", 32'(err_count), 32'(m_err_cnt));
    check("post_irq", 32'(err_irq), 32'(m_irq));
    check("post_busy", 32'(mem_rbusy | mem_wbusy), 32'h0);
    if (!rsv && !is_wr) check("hold_rdata", mem_rdata, m_last_rd);
  endtask

  task automatic clear_irq();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_irq = 1'b0;
    #1;
    check("clr_irq", 32'(err_irq), 32'h0);
    check("clr_cnt", 32'(err_count), 32'(m_err_cnt));
  endtask

  // Random address in a chosen class: RAM, mapped slot, or reserved.
  function automatic logic [31:0] rand_addr(input int kind);
    logic [15:0] p;
    if (kind == 0) begin
      do p = 16'($urandom); while (p >= 16'(IOP) && p < 16'(IOP + RSV));
    end else if (kind == 3) p = 16'(IOP + NIO + $urandom_range(0, RSV - NIO - 1));
    else p = 16'(IOP + $urandom_range(0, NIO - 1));
    return {p, 16'($urandom)};
  endfunction

  initial begin
    resetn = 1'b0; mem_addr = '0; mem_rstrb = 1'b1; mem_wmask = 4'hF; err_clr = 1'b0;
    s_rdata = '0; s_busy = '0;
    #1;
    check_reset_outs("rst");
    @(negedge clk); @(negedge clk);
    mem_rstrb = 1'b0; mem_wmask = 4'd0; resetn = 1'b1;

    access(32'h0000_0010, 1'b1, 4'h0, 0, 32'h1234_5678, 1'b0);
    access(32'h0042_0004, 1'b1, 4'h0, 4, 32'hCAFE_F00D, 1'b0);
    access(32'h0041_0000, 1'b0, 4'hF, 2, 32'h0, 1'b0);
    access(32'h0048_0000, 1'b1, 4'h0, 0, 32'h0, 1'b0);
    clear_irq();
    access(32'h0040_0000, 1'b1, 4'h0, 1000, 32'h5555_AAAA, 1'b0);
    access(32'h0044_0000, 1'b1, 4'h0, 20, 32'h0BAD_BEEF, 1'b1);
    access(32'h0041_0000, 1'b0, 4'h3, 30, 32'h0, 1'b0);
    access(32'h0043_0000, 1'b1, 4'h2, 1, 32'h0, 1'b0);
    access(32'h003F_FFFC, 1'b1, 4'h0, 0, 32'hA5A5_0001, 1'b0);
    access(32'h0050_0000, 1'b1, 4'h0, 0, 32'hA5A5_0002, 1'b0);
    access(32'h0045_0000, 1'b0, 4'hF, 0, 32'h0, 1'b0);
    access(32'h004F_0000, 1'b1, 4'h0, 0, 32'h0, 1'b1);
    access(32'h0044_0008, 1'b1, 4'h0, 8, 32'h7777_0008, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int kind, lat;
      bit rd;
      logic [3:0] wm;
      kind = $urandom_range(0, 3);
      rd = 1'($urandom_range(0, 1));
      if (rd) wm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      else    wm = 4'($urandom_range(1, 15));
      lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
      access(rand_addr(kind), rd, wm, lat, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a stalled read.
    @(negedge clk);
    mem_addr = 32'h0040_0100; mem_rstrb = 1'b1; noise(1, 32'h1111_2222); s_busy[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mem_rstrb = 1'b0; s_busy[1] = 1'b1;
    end
    #1;
    check("pre_rst_rbusy", 32'(mem_rbusy), 32'h1);
    #1;
    resetn = 1'b0; mem_rstrb = 1'b1; mem_wmask = 4'hF;
    #1;
    check_reset_outs("midrst");
    @(negedge clk);
    mem_rstrb = 1'b0; mem_wmask = 4'd0; s_busy = '0; resetn = 1'b1;
    m_err_cnt = 0; m_irq = 1'b0; m_last_rd = '0;
    access(32'h0042_0000, 1'b1, 4'h0, 1, 32'hFEED_0042, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_io_interconnect.md
Name: soc_io_interconnect

Overview:
- Parametrised successor to the SoC's fixed 6-way chip-select decoder and read mux.
- Sits between the FemtoRV32 memory port and N_IO memory-mapped peripherals plus RAM (slot 0).
- Decodes 64 KiB pages and generates per-slot select, read and write strobes.
- Adds what the fixed decoder lacks: per-slave busy handshake with CPU stall, timeout, reserved-page error detection, and error counting/IRQ.

Parameters:
- N_IO, 5, number of peripheral slots; total slots NS = N_IO+1; 1..15.
- IO_PAGE, 16'h0040, mem_addr[31:16] value of slot 1; slot k decodes page IO_PAGE+k-1.
- RSV_PAGES, 16, pages IO_PAGE..IO_PAGE+RSV_PAGES-1 reserved for I/O; must be >= N_IO.
- TIMEOUT, 255, max slave busy cycles before forced completion; 0 disables the timeout.
- ERR_VALUE, 32'h66666666, read data returned on error or timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mem_addr  in  32  CPU address
- mem_rstrb  in  1  CPU read strobe, 1-cycle pulse
- mem_wmask  in  4  CPU byte write mask; nonzero = write pulse
- mem_rdata  out  32  read data to CPU
- mem_rbusy  out  1  read stall to CPU
- mem_wbusy  out  1  write stall to CPU
- s_cs  out  NS  one-hot slot select, combinational from mem_addr (bit 0 = RAM)
- s_rd  out  NS  read strobe to selected slot
- s_wr  out  NS  write strobe to selected slot
- s_rdata  in  32*NS  slot read data, slot k at [32k+31:32k]
- s_busy  in  NS  slot busy; RAM (bit 0) normally tied 0
- err_clr  in  1  clears err_irq
- err_irq  out  1  sticky error flag
- err_count  out  16  saturating count of errors and timeouts

Behaviour:
- Decode (combinational): page = mem_addr[31:16].
  - IO_PAGE <= page < IO_PAGE+N_IO: slot = page-IO_PAGE+1.
  - IO_PAGE+N_IO <= page < IO_PAGE+RSV_PAGES: reserved; s_cs all 0.
  - All other pages: slot 0.
- Strobes: s_rd = s_cs & {NS{mem_rstrb}}; s_wr = s_cs & {NS{|mem_wmask}}. Strobes are issued only in IDLE.
  - If read and write arrive together, only the write is issued.
- FSM states: IDLE, RWAIT, WWAIT, ERR.
  - IDLE, mapped read: latch slot into sel_q; go to RWAIT.
  - IDLE, mapped write: latch slot into sel_q; go to WWAIT.
  - IDLE, reserved page with a strobe: go to ERR; the write is dropped.
  - RWAIT/WWAIT, s_busy[sel_q]=0: complete; go to IDLE.
  - RWAIT/WWAIT, busy counter reaches TIMEOUT: complete with error; go to IDLE.
  - ERR: 1 cycle, then IDLE.
- Latency:
  - A zero-wait slave completes the cycle after the strobe, with no stall.
  - mem_rbusy = (state==RWAIT) & s_busy[sel_q] & !timeout_hit.
  - mem_wbusy = (state==WWAIT) & s_busy[sel_q] & !timeout_hit.
- mem_rdata:
  - Combinational mux of s_rdata[sel_q] while in RWAIT.
  - ERR_VALUE in ERR or on timeout.
  - Otherwise holds the last completed value in a register updated at completion.
- Timeout counter: cleared on entry to RWAIT/WWAIT; increments each cycle the slave is busy. Width is clog2(TIMEOUT+1).
- Errors: reserved access or timeout sets err_irq and increments err_count.
  - err_count saturates at 16'hFFFF.
  - err_clr clears err_irq only; an error in the same cycle wins and err_irq stays 1.
- Strobes arriving outside IDLE are ignored; the CPU is stalled and must not issue them.
- Reset (async, any state): state=IDLE, sel_q=0, mem_rdata=0, mem_rbusy=0, mem_wbusy=0, err_irq=0, err_count=0, counter=0. s_rd/s_wr are forced 0 while resetn=0.

Test Plan:
- Read 0x00000010, RAM data 0x12345678, s_busy=0 -> s_rd[0] for 1 cycle; mem_rdata=0x12345678 next cycle; mem_rbusy never 1.
- Read 0x00420004, slot 3 busy for 4 cycles, data 0xCAFEF00D -> mem_rbusy high 4 cycles; mem_rdata=0xCAFEF00D on the release cycle; err_count=0.
- Write mask 4'b1111 to 0x00410000, slot 2 busy 2 cycles -> s_wr[2] one pulse; mem_wbusy high 2 cycles; no other s_wr bit set.
- Read 0x00480000 (reserved, N_IO=5) -> no s_rd; mem_rdata=0x66666666; err_irq=1; err_count=1; err_clr pulse -> err_irq=0, err_count stays 1.
- TIMEOUT=8, slot 1 busy forever -> mem_rbusy drops after 8 cycles; mem_rdata=0x66666666; err_count increments. Assert resetn=0 mid-wait -> all outputs 0 immediately.
